// File: rtl/ws2812_rx_if.sv
// rtl/ws2812_rx_if.sv - serial line input and decoded-word outputs of the WS2812 receiver
interface ws2812_rx_if #(
    parameter int PIX_W = 8
);
    logic             din;
    logic [23:0]      grb;
    logic             valid;
    logic             frame_end;
    logic [PIX_W-1:0] frame_pixels;
    logic             err;

    modport master (
        output din,
        input  grb, valid, frame_end, frame_pixels, err
    );

    modport slave (
        input  din,
        output grb, valid, frame_end, frame_pixels, err
    );
endinterface

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 single-wire decoder: pulse-width bit recovery, GRB words, frame gap detect
module ws2812_rx #(
    parameter int THRESH    = 65,
    parameter int MIN_HIGH  = 10,
    parameter int MAX_HIGH  = 200,
    parameter int RESET_GAP = 5000,
    parameter int PIX_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    ws2812_rx_if.slave   bus
);
    localparam int LCNT_W = $clog2(RESET_GAP + 1);

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               sync3_q, sync3_d;
    logic [7:0]         hcnt_q, hcnt_d;
    logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
    logic [22:0]        sreg_q, sreg_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [23:0]        grb_q, grb_d;
    logic               valid_q, valid_d;
    logic               frame_end_q, frame_end_d;
    logic [PIX_W-1:0]   frame_pixels_q, frame_pixels_d;
    logic               err_q, err_d;

    logic               rise;
    logic               fall;
    logic               gap_hit;
    logic               bit_val;

    // Next-state logic: synchroniser, width counters, decode FSM and output pulses
    always_comb begin
        sync1_d = bus.din;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        rise    = sync2_q & ~sync3_q;
        fall    = ~sync2_q & sync3_q;

        // Width counters run free on the synchronised level; the FSM only samples them.
        hcnt_d = '0;
        if (sync2_q) begin
            hcnt_d = (hcnt_q == 8'hFF) ? hcnt_q : hcnt_q + 8'd1;
        end
        lcnt_d = '0;
        if (!sync2_q) begin
            lcnt_d = (lcnt_q == LCNT_W'(RESET_GAP)) ? lcnt_q : lcnt_q + 1'b1;
        end
        gap_hit = !sync2_q && (lcnt_d == LCNT_W'(RESET_GAP));
        bit_val = (hcnt_q >= 8'(THRESH));

        state_d        = state_q;
        sreg_d         = sreg_q;
        bit_cnt_d      = bit_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        grb_d          = grb_q;
        valid_d        = 1'b0;
        frame_end_d    = 1'b0;
        frame_pixels_d = frame_pixels_q;
        err_d          = 1'b0;

        case (state_q)
            WAIT_GAP: begin
                if (gap_hit) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    if (hcnt_q < 8'(MIN_HIGH)) begin
                        err_d = 1'b1;
                    end else if (bit_cnt_q == 5'd23) begin
                        grb_d     = {sreg_q, bit_val};
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                        pix_cnt_d = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 1'b1;
                    end else begin
                        sreg_d    = {sreg_q[21:0], bit_val};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else if (hcnt_d > 8'(MAX_HIGH)) begin
                    // Stuck-high line: abandon the frame and relock on the next gap.
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    state_d   = WAIT_GAP;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (gap_hit) begin
                    frame_end_d    = 1'b1;
                    frame_pixels_d = pix_cnt_q;
                    err_d          = (bit_cnt_q != 5'd0);
                    bit_cnt_d      = '0;
                    pix_cnt_d      = '0;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = WAIT_GAP;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= WAIT_GAP;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            hcnt_q         <= '0;
            lcnt_q         <= '0;
            sreg_q         <= '0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            grb_q          <= '0;
            valid_q        <= 1'b0;
            frame_end_q    <= 1'b0;
            frame_pixels_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            hcnt_q         <= hcnt_d;
            lcnt_q         <= lcnt_d;
            sreg_q         <= sreg_d;
            bit_cnt_q      <= bit_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            grb_q          <= grb_d;
            valid_q        <= valid_d;
            frame_end_q    <= frame_end_d;
            frame_pixels_q <= frame_pixels_d;
            err_q          <= err_d;
        end
    end

    assign bus.grb          = grb_q;
    assign bus.valid        = valid_q;
    assign bus.frame_end    = frame_end_q;
    assign bus.frame_pixels = frame_pixels_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - pulse-level reference model and per-cycle checker for ws2812_rx
module tb_ws2812_rx;
    localparam int GAP = 5000;
    localparam int FGAP = 5010;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    ws2812_rx_if #(.PIX_W(8)) bus ();

    ws2812_rx #(
        .THRESH(65), .MIN_HIGH(10), .MAX_HIGH(200), .RESET_GAP(GAP), .PIX_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        bit          ev_v;
        bit          ev_e;
        bit          ev_fe;
        logic [23:0] word;
        logic [7:0]  pix;
    } ev_t;

    ev_t evq[$];

    bit          m_locked = 0;
    bit          m_in_frame = 0;
    int          m_bits = 0;
    int          m_pix = 0;
    logic [23:0] m_word = '0;
    logic [23:0] exp_grb = '0;
    logic [7:0]  exp_fp = '0;

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_fe = 0;
    logic [23:0] last_words[$];
    logic [7:0]  last_fp = '0;
    bit          last_fe_err = 0;

    function automatic ev_t new_ev(int at);
        ev_t x;
        x.at = at; x.ev_v = 0; x.ev_e = 0; x.ev_fe = 0; x.word = '0; x.pix = '0;
        return x;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        evq.delete();
        m_locked = 0; m_in_frame = 0; m_bits = 0; m_pix = 0;
        exp_grb = '0; exp_fp = '0;
    endtask

    // Synchronised edges trail the pin by 3 cycles; a pulse of N pin cycles measures N.
    task automatic send_high(int n);
        int  r0;
        ev_t x;
        r0 = cyc;
        bus.din = 1'b1;
        if (m_locked) begin
            if (n > 200) begin
                x = new_ev(r0 + 203); x.ev_e = 1; evq.push_back(x);
                m_locked = 0; m_in_frame = 0; m_bits = 0; m_pix = 0;
            end else begin
                m_in_frame = 1;
                x = new_ev(r0 + n + 3);
                if (n < 10) begin
                    x.ev_e = 1; evq.push_back(x);
                end else begin
                    m_word = {m_word[22:0], (n >= 65)};
                    m_bits++;
                    if (m_bits == 24) begin
                        x.ev_v = 1; x.word = m_word; evq.push_back(x);
                        m_bits = 0;
                        if (m_pix < 255) m_pix++;
                    end
                end
            end
        end
        wait_cycles(n);
    endtask

    task automatic send_low(int n);
        int  f0;
        ev_t x;
        f0 = cyc;
        bus.din = 1'b0;
        if (m_locked && m_in_frame && n >= GAP) begin
            x = new_ev(f0 + GAP + 2);
            x.ev_fe = 1; x.pix = 8'(m_pix); x.ev_e = (m_bits != 0);
            evq.push_back(x);
            m_bits = 0; m_pix = 0; m_in_frame = 0;
        end else if (!m_locked && n >= GAP) begin
            m_locked = 1;
        end
        wait_cycles(n);
    endtask

    task automatic send_bits(logic [23:0] w, int nbits, bit slow, int tail);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (slow) send_high(w[i] ? 100 : 30);
            else      send_high(w[i] ? 70 : 20);
            if (i == 0)    send_low(tail);
            else if (slow) send_low(w[i] ? 30 : 100);
            else           send_low(w[i] ? 10 : 60);
        end
    endtask

    task automatic do_reset();
        bus.din = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_outputs", {29'd0, bus.valid, bus.err, bus.frame_end, bus.frame_pixels, bus.grb}, 64'd0);
        wait_cycles(2);
        rst = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model's event schedule
    always @(negedge clk) begin
        ev_t x;
        bit  ev, ee, efe;
        ev = 0; ee = 0; efe = 0;
        while (evq.size() > 0 && evq[0].at < cyc) begin
            x = evq.pop_front();
            checks++; failures++;
            $display("FAIL missed_event at=%0d now=%0d", x.at, cyc);
        end
        if (evq.size() > 0 && evq[0].at == cyc) begin
            x = evq.pop_front();
            ev = x.ev_v; ee = x.ev_e; efe = x.ev_fe;
            if (x.ev_v)  exp_grb = x.word;
            if (x.ev_fe) exp_fp = x.pix;
        end
        checks++;
        if ({bus.valid, bus.err, bus.frame_end, bus.grb, bus.frame_pixels} !== {ev, ee, efe, exp_grb, exp_fp}) begin
            failures++;
            $display("FAIL cycle_outputs cyc=%0d got v/e/fe=%b%b%b grb=%h fp=%0d exp v/e/fe=%b%b%b grb=%h fp=%0d",
                     cyc, bus.valid, bus.err, bus.frame_end, bus.grb, bus.frame_pixels,
                     ev, ee, efe, exp_grb, exp_fp);
        end
        if (bus.valid === 1'b1) begin n_valid++; last_words.push_back(bus.grb); end
        if (bus.err === 1'b1) n_err++;
        if (bus.frame_end === 1'b1) begin n_fe++; last_fp = bus.frame_pixels; last_fe_err = bus.err; end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int npulse;
        int h;
        int lo;
        int r;
        bus.din = 1'b0;
        #1;
        do_reset();

        // One slow-timed word after the lock gap
        send_low(FGAP);
        send_bits(24'hFF0055, 24, 1'b1, FGAP);
        chk("w1_count", 64'(n_valid), 64'd1);
        chk("w1_grb", 64'(bus.grb), 64'hFF0055);
        chk("w1_fp", 64'(last_fp), 64'd1);
        chk("w1_nerr", 64'(n_err), 64'd0);

        // Two back-to-back words
        send_bits(24'h123456, 24, 1'b0, 10);
        send_bits(24'hABCDEF, 24, 1'b0, FGAP);
        chk("w2_count", 64'(n_valid), 64'd3);
        chk("w2_first", 64'(last_words[1]), 64'h123456);
        chk("w2_second", 64'(last_words[2]), 64'hABCDEF);
        chk("w2_fp", 64'(last_fp), 64'd2);
        chk("w2_fe_err", 64'(last_fe_err), 64'd0);

        // Partial word at frame end
        send_bits(24'h000A5C, 12, 1'b0, FGAP);
        chk("part_count", 64'(n_valid), 64'd3);
        chk("part_fp", 64'(last_fp), 64'd0);
        chk("part_fe_err", 64'(last_fe_err), 64'd1);
        chk("part_nfe", 64'(n_fe), 64'd3);

        // Glitch inside a word is dropped
        send_bits(24'h00000F, 12, 1'b0, 10);
        send_high(5);
        send_low(10);
        send_bits(24'h000F00, 12, 1'b0, FGAP);
        chk("glitch_grb", 64'(bus.grb), 64'h00FF00);
        chk("glitch_nerr", 64'(n_err), 64'd2);
        chk("glitch_fp", 64'(last_fp), 64'd1);

        // Stuck-high line, then relock
        send_high(300);
        send_low(100);
        send_bits(24'hC3A51E, 24, 1'b0, FGAP);
        chk("stuck_nerr", 64'(n_err), 64'd3);
        chk("stuck_count", 64'(n_valid), 64'd4);
        send_bits(24'hC3A51E, 24, 1'b0, FGAP);
        chk("relock_grb", 64'(bus.grb), 64'hC3A51E);

        // Reset mid-word, unlocked word ignored, then a clean word
        send_bits(24'h0003FF, 10, 1'b0, 60);
        do_reset();
        nv = n_valid;
        send_low(100);
        send_bits(24'h0F0F0F, 24, 1'b0, FGAP);
        chk("unlocked_count", 64'(n_valid), 64'(nv));
        send_bits(24'h0F0F0F, 24, 1'b0, FGAP);
        chk("post_reset_count", 64'(n_valid), 64'(nv + 1));
        chk("post_reset_grb", 64'(bus.grb), 64'h0F0F0F);

        // Random frames with boundary pulse widths and one just-short gap
        for (int f = 0; f < 2; f++) begin
            npulse = $urandom_range(40, 24);
            for (int p = 0; p < npulse; p++) begin
                r = $urandom_range(9, 0);
                case (r)
                    0: h = 9;
                    1: h = 10;
                    2: h = 64;
                    3: h = 65;
                    4: h = 200;
                    5: h = $urandom_range(9, 1);
                    default: h = $urandom_range(200, 10);
                endcase
                send_high(h);
                if (p == npulse - 1)        lo = FGAP;
                else if (f == 0 && p == 10) lo = GAP - 1;
                else                        lo = $urandom_range(40, 1);
                send_low(lo);
            end
        end

        wait_cycles(10);
        chk("queue_drained", 64'(evq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
